// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe turn sequencer: owns the 3x3 board, commits moves on a press/release
// handshake, scores the 8 lines, and blinks the winning cells while the game is over.
module ttt_game_ctrl #(
  parameter int BLINK_TICKS = 250
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        button,
  input  logic [8:0]  select,
  output logic [17:0] board,
  output logic [1:0]  turn,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic [7:0]  win_line,
  output logic [8:0]  win_cells,
  output logic [3:0]  move_count,
  output logic        invalid,
  output logic        blink
);

  typedef enum logic [1:0] {S_WAIT, S_HOLD, S_EVAL, S_OVER} state_t;

  localparam int            CW      = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_TICKS - 1);

  // Cell masks per win_line bit: rows 0-2, cols 0-2, main diag, anti diag.
  localparam logic [7:0][8:0] LINE_MASK = {
    9'h054, 9'h111, 9'h124, 9'h092, 9'h049, 9'h1C0, 9'h038, 9'h007
  };

  state_t        state_q, state_d;
  logic [17:0]   board_q, board_d;
  logic [1:0]    turn_q, turn_d;
  logic [1:0]    winner_q, winner_d;
  logic [7:0]    win_line_q, win_line_d;
  logic [3:0]    move_count_q, move_count_d;
  logic          invalid_q, invalid_d;
  logic          blink_q, blink_d;
  logic          accepted_q, accepted_d;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;

  logic [8:0] own, occupied;
  logic [7:0] line_hit;
  logic       one_hot, legal, decisive;

  for (genvar c = 0; c < 9; c++) begin : g_cell
    assign own[c]      = (board_q[2*c +: 2] == turn_q);
    assign occupied[c] = |board_q[2*c +: 2];
  end

  for (genvar l = 0; l < 8; l++) begin : g_line
    assign line_hit[l] = ((own & LINE_MASK[l]) == LINE_MASK[l]);
  end

  assign one_hot  = (select != 9'd0) && ((select & (select - 9'd1)) == 9'd0);
  assign legal    = one_hot && ((select & occupied) == 9'd0);
  assign decisive = winner_q[0] ^ winner_q[1];

  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    turn_d       = turn_q;
    winner_d     = winner_q;
    win_line_d   = win_line_q;
    move_count_d = move_count_q;
    invalid_d    = 1'b0;
    accepted_d   = accepted_q;
    blink_d      = 1'b0;
    blink_cnt_d  = '0;

    case (state_q)
      S_WAIT: begin
        if (!button) begin
          state_d = S_HOLD;
          if (legal) begin
            for (int c = 0; c < 9; c++)
              if (select[c]) board_d[2*c +: 2] = turn_q;
            if (move_count_q < 4'd9) move_count_d = move_count_q + 4'd1;
            accepted_d = 1'b1;
          end else begin
            invalid_d  = 1'b1;
            accepted_d = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (button) state_d = accepted_q ? S_EVAL : S_WAIT;
      end
      S_EVAL: begin
        if (|line_hit) begin
          winner_d   = turn_q;
          win_line_d = line_hit;
          state_d    = S_OVER;
        end else if (move_count_q == 4'd9) begin
          winner_d   = 2'b11;
          win_line_d = '0;
          state_d    = S_OVER;
        end else begin
          turn_d  = ~turn_q;
          state_d = S_WAIT;
        end
      end
      S_OVER: begin
        if (!button) begin
          board_d      = '0;
          move_count_d = '0;
          winner_d     = '0;
          win_line_d   = '0;
          turn_d       = 2'b01;
          accepted_d   = 1'b0;
          state_d      = S_HOLD;
        end
      end
      default: state_d = S_WAIT;
    endcase

    // Blink only while staying in OVER after a win, so a restart edge never flashes.
    if (state_q == S_OVER && state_d == S_OVER && decisive) begin
      if (blink_cnt_q == CNT_MAX) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_d     = blink_q;
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q      <= S_WAIT;
      board_q      <= '0;
      turn_q       <= 2'b01;
      winner_q     <= '0;
      win_line_q   <= '0;
      move_count_q <= '0;
      invalid_q    <= 1'b0;
      blink_q      <= 1'b0;
      accepted_q   <= 1'b0;
      blink_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      turn_q       <= turn_d;
      winner_q     <= winner_d;
      win_line_q   <= win_line_d;
      move_count_q <= move_count_d;
      invalid_q    <= invalid_d;
      blink_q      <= blink_d;
      accepted_q   <= accepted_d;
      blink_cnt_q  <= blink_cnt_d;
    end
  end

  always_comb begin
    win_cells = '0;
    for (int l = 0; l < 8; l++)
      if (win_line_q[l]) win_cells = win_cells | LINE_MASK[l];
  end

  assign board      = board_q;
  assign turn       = turn_q;
  assign winner     = winner_q;
  assign game_over  = (state_q == S_OVER);
  assign win_line   = win_line_q;
  assign move_count = move_count_q;
  assign invalid    = invalid_q;
  assign blink      = blink_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: hand-computed boards for wins, draws, rejects and resets.
module tb_ttt_game_ctrl;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        button = 1'b1;
  logic [8:0]  select = '0;
  logic [17:0] board;
  logic [1:0]  turn, winner;
  logic        game_over, invalid, blink;
  logic [7:0]  win_line;
  logic [8:0]  win_cells;
  logic [3:0]  move_count;

  int n_checks = 0;
  int n_fail   = 0;

  ttt_game_ctrl #(.BLINK_TICKS(250)) dut (
    .clock(clock), .rst(rst), .button(button), .select(select),
    .board(board), .turn(turn), .winner(winner), .game_over(game_over),
    .win_line(win_line), .win_cells(win_cells), .move_count(move_count),
    .invalid(invalid), .blink(blink)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    button = 1'b1;
    select = '0;
    rst    = 1'b0;
    #3;
    rst    = 1'b1;
    tick();
  endtask

  // Press, release, and let EVAL resolve: ends one edge after EVAL.
  task automatic move(input logic [8:0] sel);
    select = sel;
    button = 1'b0;
    tick();
    button = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    button = 1'b1;
    #12;
    n_checks++;
    if (board !== 18'h0 || turn !== 2'b01 || winner !== 2'b00 || game_over !== 1'b0 ||
        win_line !== 8'h0 || win_cells !== 9'h0 || move_count !== 4'd0 ||
        invalid !== 1'b0 || blink !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: board=%h turn=%b winner=%b over=%b line=%h cells=%h cnt=%0d inv=%b blink=%b",
               board, turn, winner, game_over, win_line, win_cells, move_count, invalid, blink);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_first_move();
    do_reset();
    select = 9'h001;
    button = 1'b0;
    tick();
    n_checks++;
    if (board !== 18'h00001 || move_count !== 4'd1 || invalid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_commit: board=%h cnt=%0d inv=%b want 00001 1 0", board, move_count, invalid);
    end
    button = 1'b1;
    tick();
    n_checks++;
    if (turn !== 2'b01 || invalid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_eval_turn: turn=%b inv=%b want 01 0", turn, invalid);
    end
    tick();
    n_checks++;
    if (turn !== 2'b10 || game_over !== 1'b0 || invalid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_turn_toggle: turn=%b over=%b inv=%b want 10 0 0", turn, game_over, invalid);
    end
  endtask

  task automatic test_invalid();
    logic [8:0] bad [3];
    bad[0] = 9'h001; bad[1] = 9'h003; bad[2] = 9'h000;
    do_reset();
    move(9'h001);
    for (int k = 0; k < 3; k++) begin
      select = bad[k];
      button = 1'b0;
      tick();
      n_checks++;
      if (invalid !== 1'b1 || board !== 18'h00001 || move_count !== 4'd1 || turn !== 2'b10) begin
        n_fail++;
        $display("FAIL invalid_pulse[%0d]: inv=%b board=%h cnt=%0d turn=%b want 1 00001 1 10",
                 k, invalid, board, move_count, turn);
      end
      tick();
      n_checks++;
      if (invalid !== 1'b0) begin
        n_fail++;
        $display("FAIL invalid_width[%0d]: inv=%b want 0", k, invalid);
      end
      button = 1'b1;
      tick();
      tick();
    end
    move(9'h002);
    n_checks++;
    if (board !== 18'h00009 || turn !== 2'b01 || move_count !== 4'd2) begin
      n_fail++;
      $display("FAIL after_invalid_move: board=%h turn=%b cnt=%0d want 00009 01 2", board, turn, move_count);
    end
  endtask

  task automatic test_row_win();
    do_reset();
    move(9'h001); move(9'h008); move(9'h002); move(9'h010); move(9'h004);
    n_checks++;
    if (winner !== 2'b01 || win_line !== 8'h01 || win_cells !== 9'h007 || game_over !== 1'b1 ||
        board !== 18'h00295 || move_count !== 4'd5 || blink !== 1'b0) begin
      n_fail++;
      $display("FAIL row_win: win=%b line=%h cells=%h over=%b board=%h cnt=%0d blink=%b",
               winner, win_line, win_cells, game_over, board, move_count, blink);
    end
    repeat (249) tick();
    n_checks++;
    if (blink !== 1'b0) begin
      n_fail++;
      $display("FAIL blink_before_toggle: blink=%b want 0", blink);
    end
    tick();
    n_checks++;
    if (blink !== 1'b1) begin
      n_fail++;
      $display("FAIL blink_first_toggle: blink=%b want 1", blink);
    end
    repeat (250) tick();
    n_checks++;
    if (blink !== 1'b0) begin
      n_fail++;
      $display("FAIL blink_second_toggle: blink=%b want 0", blink);
    end
    // Press in OVER restarts; cell 5 must never be written.
    select = 9'h020;
    button = 1'b0;
    tick();
    n_checks++;
    if (board !== 18'h0 || invalid !== 1'b0 || game_over !== 1'b0 || winner !== 2'b00 ||
        win_line !== 8'h0 || turn !== 2'b01 || move_count !== 4'd0 || blink !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_press: board=%h inv=%b over=%b win=%b line=%h turn=%b cnt=%0d blink=%b",
               board, invalid, game_over, winner, win_line, turn, move_count, blink);
    end
    button = 1'b1;
    tick();
    move(9'h100);
    n_checks++;
    if (board !== 18'h10000 || turn !== 2'b10 || move_count !== 4'd1) begin
      n_fail++;
      $display("FAIL restart_then_move: board=%h turn=%b cnt=%0d want 10000 10 1", board, turn, move_count);
    end
  endtask

  task automatic test_draw();
    logic [8:0] seq [9];
    seq[0] = 9'h001; seq[1] = 9'h002; seq[2] = 9'h004; seq[3] = 9'h010; seq[4] = 9'h008;
    seq[5] = 9'h020; seq[6] = 9'h080; seq[7] = 9'h040; seq[8] = 9'h100;
    do_reset();
    for (int k = 0; k < 8; k++) move(seq[k]);
    n_checks++;
    if (game_over !== 1'b0 || move_count !== 4'd8 || turn !== 2'b01) begin
      n_fail++;
      $display("FAIL draw_before_last: over=%b cnt=%0d turn=%b want 0 8 01", game_over, move_count, turn);
    end
    move(seq[8]);
    n_checks++;
    if (winner !== 2'b11 || win_line !== 8'h0 || win_cells !== 9'h0 || game_over !== 1'b1 ||
        board !== 18'h16A59 || move_count !== 4'd9) begin
      n_fail++;
      $display("FAIL draw_result: win=%b line=%h cells=%h over=%b board=%h cnt=%0d",
               winner, win_line, win_cells, game_over, board, move_count);
    end
    repeat (300) tick();
    n_checks++;
    if (blink !== 1'b0) begin
      n_fail++;
      $display("FAIL draw_blink: blink=%b want 0", blink);
    end
  endtask

  task automatic test_double_line();
    logic [8:0] seq [9];
    seq[0] = 9'h002; seq[1] = 9'h010; seq[2] = 9'h004; seq[3] = 9'h020; seq[4] = 9'h008;
    seq[5] = 9'h080; seq[6] = 9'h040; seq[7] = 9'h100; seq[8] = 9'h001;
    do_reset();
    for (int k = 0; k < 9; k++) move(seq[k]);
    n_checks++;
    if (winner !== 2'b01 || win_line !== 8'h09 || win_cells !== 9'h04F || game_over !== 1'b1 ||
        move_count !== 4'd9) begin
      n_fail++;
      $display("FAIL double_line: win=%b line=%h cells=%h over=%b cnt=%0d want 01 09 04f 1 9",
               winner, win_line, win_cells, game_over, move_count);
    end
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    move(9'h001);
    select = 9'h010;
    button = 1'b0;
    tick();
    n_checks++;
    if (board !== 18'h00201 || move_count !== 4'd2) begin
      n_fail++;
      $display("FAIL hold_commit: board=%h cnt=%0d want 00201 2", board, move_count);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (board !== 18'h0 || turn !== 2'b01 || winner !== 2'b00 || game_over !== 1'b0 ||
        win_line !== 8'h0 || move_count !== 4'd0 || invalid !== 1'b0 || blink !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_hold: board=%h turn=%b win=%b over=%b line=%h cnt=%0d inv=%b blink=%b",
               board, turn, winner, game_over, win_line, move_count, invalid, blink);
    end
    button = 1'b1;
    #2;
    rst = 1'b1;
    tick();
    move(9'h004);
    n_checks++;
    if (board !== 18'h00010 || turn !== 2'b10 || move_count !== 4'd1) begin
      n_fail++;
      $display("FAIL move_after_reset: board=%h turn=%b cnt=%0d want 00010 10 1", board, turn, move_count);
    end
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_invalid();
    test_row_win();
    test_draw();
    test_double_line();
    test_reset_in_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ttt_game_ctrl.md
Name: ttt_game_ctrl

Overview:
- Turn-sequencing controller for the 3x3 tic-tac-toe board.
- Owns the board register (9 cells x 2 bits).
- Validates and commits moves on a button press/release handshake, detects wins and draws over the 8 lines, alternates turns, and handles restart after game over.
- Sits between the switch/button inputs (ms-rate clock domain) and the square renderers, which consume board/win_cells/blink.

Parameters:
- BLINK_TICKS, 250: clock cycles per half-period of the winning-line blink (default = 250 ms at the 1 kHz game clock).

Ports:
- clock  input  1  game clock (ms tick clock)
- rst  input  1  asynchronous, active-low reset
- button  input  1  move/restart button, active-low, already synchronous to clock
- select  input  9  cell select from switches, bit i = cell i, row-major, cell 0 top-left
- board  output  18  cell i at [2i+1:2i]: 00 empty, 01 X (player 1), 10 O (player 2)
- turn  output  2  player to move: 01 or 10
- winner  output  2  00 none, 01 X won, 10 O won, 11 draw
- game_over  output  1  high while in OVER
- win_line  output  8  bits 0-2 rows 0-2; bits 3-5 cols 0-2; bit 6 diag {0,4,8}; bit 7 diag {2,4,6}
- win_cells  output  9  OR of the cells of all set win_line bits (combinational from win_line)
- move_count  output  4  committed moves, 0..9
- invalid  output  1  one-cycle pulse on a rejected press
- blink  output  1  highlight blink phase for win_cells

Behaviour:
- Reset, asynchronous on rst=0:
  - Registers: state=WAIT, board=0, turn=01, winner=00, win_line=0, move_count=0, invalid=0, blink=0, accepted=0, blink counter=0.
  - Reset mid-operation in any state forces these values immediately. A partially handled press is discarded.
- All other state changes occur on posedge clock.
- FSM states: WAIT, HOLD, EVAL, OVER.
- WAIT, on button==0 (press):
  - Legal = select has exactly one bit set AND that cell is 00.
  - If legal: write turn into the cell; move_count+1; accepted=1; go to HOLD. The board updates on the same edge.
  - If illegal (select==0, more than one bit set, or cell occupied): invalid=1 for exactly one cycle; board unchanged; accepted=0; go to HOLD.
  - A button held low through reset release counts as a press on the first clock in WAIT.
- HOLD:
  - Stay while button==0. select changes are ignored.
  - On button==1: go to EVAL if accepted=1, else go to WAIT.
- EVAL (exactly one cycle):
  - Check all 8 lines for three cells equal to turn.
  - Any line matches: winner=turn; win_line gets all matching bits (a double line sets 2 bits); go to OVER.
  - Else if move_count==9: winner=11, win_line=0, go to OVER.
  - Else: toggle turn (01<->10), go to WAIT.
  - A win on the 9th move is a win, not a draw.
- Latency: release to updated turn/winner = 2 clock edges (HOLD->EVAL, EVAL->next state).
- OVER:
  - game_over=1; board frozen; select ignored.
  - On button==0: clear board, move_count, winner and win_line; turn=01; accepted=0; go to HOLD. Release then returns to WAIT.
  - invalid is not asserted in OVER.
- Blink:
  - Active only in OVER with winner 01 or 10. The counter counts 0..BLINK_TICKS-1, then wraps and toggles blink.
  - In other states, or on a draw: counter=0 and blink=0.
  - blink starts at 0 on entry to OVER.
- invalid is a registered pulse; it is never high for 2 consecutive cycles.
- move_count never exceeds 9 and never wraps.

Test Plan:
- Reset, then press/release with select=9'h001 -> board=18'h00001, move_count=1, after 2 edges turn=10, invalid never high.
- Press with select=9'h001 again (occupied) or 9'h003 (two bits) -> invalid high for 1 cycle; board, turn and move_count unchanged; after release state=WAIT.
- Moves X0, O3, X1, O4, X2 -> winner=01, win_line=8'h01, win_cells=9'h007, game_over=1; blink toggles every 250 cycles; a press on cell 5 does not change the board.
- Full game without a line (X:0,2,3,7,8 / O:1,4,5,6) -> after the 9th move winner=11, win_line=0, blink stays 0.
- X completes row 0 and column 0 together on the 9th move -> winner=01, win_line=8'h09, win_cells=9'h04F.
- Assert rst low while in HOLD after a legal press -> all outputs return to reset values at once. In OVER, press/release -> board=0, turn=01, move_count=0, state WAIT.
